// File: rtl/deser400_tp_pkg.sv
// Shared constants, state type and trigger helper for the DESER400 test-point capture block.
package deser400_tp_pkg;

  localparam logic [1:0] TRIG_IMM     = 2'd0;
  localparam logic [1:0] TRIG_A_RISE  = 2'd1;
  localparam logic [1:0] TRIG_B_RISE  = 2'd2;
  localparam logic [1:0] TRIG_AB_HIGH = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  // tp[0] is tpa, tp[1] is tpb; tp_prev is the same pair one cycle earlier.
  function automatic logic trig_hit(input logic [1:0] mode, input logic [1:0] tp,
                                    input logic [1:0] tp_prev);
    logic hit;
    hit = 1'b0;
    case (mode)
      TRIG_IMM:     hit = 1'b1;
      TRIG_A_RISE:  hit = tp[0] & ~tp_prev[0];
      TRIG_B_RISE:  hit = tp[1] & ~tp_prev[1];
      TRIG_AB_HIGH: hit = tp[0] & tp[1];
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/deser400_tp_capture_if.sv
// Readout stream of the test-point capture: one 2-bit sample per valid/ready handshake.
interface deser400_tp_capture_if;
  logic       rd_valid;
  logic [1:0] rd_data;
  logic       rd_ready;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/tp_capture_ram.sv
// 2-bit simple dual-port RAM: synchronous write, registered read.
module tp_capture_ram #(
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [1:0]           wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [1:0]           rdata
);

  logic [1:0] mem [2**AddrWidth];
  logic [1:0] rdata_q;

  // Write port; storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/deser400_tp_capture.sv
// Logic-analyser capture of the tpa/tpb probe lines: arm, trigger, record, stream out.
module deser400_tp_capture
  import deser400_tp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tpa,
  input  logic                         tpb,
  input  logic                         arm,
  input  logic                         abort,
  input  logic [1:0]                   trig_mode,
  input  logic [7:0]                   prescale,
  output logic                         armed,
  output logic                         busy,
  output logic                         done,
  deser400_tp_capture_if.master        rd
);

  state_e                state_q, state_d;
  logic [1:0]            tp_q, tp_prev_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            prescale_q, prescale_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [DEPTH_LOG2-1:0] raddr;
  logic [1:0]            ram_rdata;
  logic                  fire;

  // Probe input stage; tp_prev_q always trails tp_q so no false edge appears after arming.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tp_q      <= '0;
      tp_prev_q <= '0;
    end else begin
      tp_q      <= {tpb, tpa};
      tp_prev_q <= tp_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      prescale_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      prescale_q <= prescale_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state, write-port and read-address decode.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    prescale_d = prescale_q;
    rd_valid_d = 1'b0;
    we         = 1'b0;
    waddr      = wr_ptr_q;
    raddr      = rd_ptr_q;
    fire       = rd_valid_q & rd.rd_ready;

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d    = StArmed;
          wr_ptr_d   = '0;
          prescale_d = prescale;
        end
      end
      StArmed: begin
        if (trig_hit(trig_mode, tp_q, tp_prev_q)) begin
          we       = 1'b1;
          waddr    = '0;
          wr_ptr_d = DEPTH_LOG2'(1);
          cnt_d    = prescale_q;
          state_d  = StCapture;
        end
      end
      StCapture: begin
        if (cnt_q == '0) begin
          we    = 1'b1;
          cnt_d = prescale_q;
          if (wr_ptr_q == '1) begin
            state_d  = StDone;
            rd_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        rd_valid_d = 1'b1;
        if (fire) begin
          if (rd_ptr_q == '1) begin
            state_d    = StIdle;
            rd_valid_d = 1'b0;
          end else begin
            // Prefetch the next address so the registered read keeps 1 sample/clk.
            rd_ptr_d = rd_ptr_q + 1'b1;
            raddr    = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort beats everything, including a simultaneous arm.
    if (abort) begin
      state_d    = StIdle;
      we         = 1'b0;
      rd_valid_d = 1'b0;
    end
  end

  tp_capture_ram #(
    .AddrWidth(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .waddr(waddr),
    .wdata(tp_q),
    .raddr(raddr),
    .rdata(ram_rdata)
  );

  assign armed       = (state_q == StArmed);
  assign busy        = (state_q == StArmed) || (state_q == StCapture);
  assign done        = (state_q == StDone);
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_valid_q ? ram_rdata : 2'b00;

endmodule

// File: tb/tb_deser400_tp_capture.sv
// Randomised bench for deser400_tp_capture against a pin-history reference model.
module tb_deser400_tp_capture;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tpa = 1'b0;
  logic       tpb = 1'b0;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] trig_mode = 2'd0;
  logic [7:0] prescale = 8'd0;
  logic       armed, busy, done;

  deser400_tp_capture_if rd_if ();

  deser400_tp_capture #(
    .DEPTH_LOG2(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tpa      (tpa),
    .tpb      (tpb),
    .arm      (arm),
    .abort    (abort),
    .trig_mode(trig_mode),
    .prescale (prescale),
    .armed    (armed),
    .busy     (busy),
    .done     (done),
    .rd       (rd_if)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [1:0] hist[$];
  logic [1:0] exp_q[N];
  logic [1:0] got[N];
  int         arm_edge = 0;
  int         cur_mode = 0;
  int         cur_ps = 0;
  int         gen = 0;
  int         gcnt = 0;
  logic [1:0] man_tp = 2'b00;

  // Pin history: hist[e] = {tpb,tpa} as seen by the DUT at rising edge e.
  always @(posedge clk) hist.push_back({tpb, tpa});

  // Probe generator: 0 manual, 1 tpa period-4 counter, 2 tpb toggling, 3 random.
  always @(negedge clk) begin
    #1;
    case (gen)
      0: {tpb, tpa} = man_tp;
      1: begin
        tpa  = 1'((gcnt >> 1) & 1);
        tpb  = man_tp[1];
        gcnt = gcnt + 1;
      end
      2: begin
        tpb = ~tpb;
        tpa = man_tp[0];
      end
      default: {tpb, tpa} = 2'($urandom_range(0, 3));
    endcase
  end

  initial rd_if.rd_ready = 1'b0;

  function automatic bit hit_at(input int mode, input int t);
    logic [1:0] cur, prev;
    cur  = hist[t];
    prev = hist[t-1];
    case (mode)
      0:       return 1'b1;
      1:       return cur[0] && !prev[0];
      2:       return cur[1] && !prev[1];
      default: return cur == 2'b11;
    endcase
  endfunction

  // Sample i of the record is the pin value i*(prescale+1) edges after the trigger edge.
  function automatic bit build_expected();
    for (int t = arm_edge; t < hist.size(); t++) begin
      if (hit_at(cur_mode, t)) begin
        for (int i = 0; i < N; i++) begin
          int idx;
          idx = t + i * (cur_ps + 1);
          if (idx >= hist.size()) return 1'b0;
          exp_q[i] = hist[idx];
        end
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic do_arm(input int mode, input int ps);
    @(negedge clk);
    arm       = 1'b1;
    trig_mode = 2'(mode);
    prescale  = 8'(ps);
    @(negedge clk);
    arm      = 1'b0;
    arm_edge = hist.size() - 1;
    cur_mode = mode;
    cur_ps   = ps;
  endtask

  task automatic wait_done(input int bound, output int busy_cnt);
    int k;
    busy_cnt = 0;
    k = 0;
    while (!done && k < bound) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (done !== 1'b1) $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, k);
    else n_pass++;
    k = 0;
    while (!rd_if.rd_valid && k < 3) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k > 2) $display("FAIL valid_latency: rd_valid after %0d cycles, required <=2", k);
    else n_pass++;
  endtask

  task automatic read_and_check(input int n_take, input int duty);
    int         n, k;
    bit         pv, pr, r, found;
    logic       v;
    logic [1:0] d, pd;
    n = 0; k = 0; pv = 0; pr = 0; pd = '0;
    found = build_expected();
    n_checks++;
    if (!found) $display("FAIL trigger_found: no trigger in pin history, required one");
    else n_pass++;
    while (n < n_take && k < N * 20) begin
      v = rd_if.rd_valid;
      d = rd_if.rd_data;
      if (pv && !pr) begin
        n_checks++;
        if (v !== 1'b1 || d !== pd)
          $display("FAIL stall_hold: valid=%0b data=%0d, required 1/%0d", v, d, pd);
        else n_pass++;
      end
      r = ($urandom_range(0, 99) < duty);
      rd_if.rd_ready = r;
      if (v && r) begin
        got[n] = d;
        n_checks++;
        if (d !== exp_q[n]) $display("FAIL sample[%0d]: got %b, required %b", n, d, exp_q[n]);
        else n_pass++;
        n++;
      end
      pv = v; pr = r; pd = d;
      @(negedge clk);
      k++;
    end
    rd_if.rd_ready = 1'b0;
    n_checks++;
    if (n != n_take) $display("FAIL read_count: got %0d samples, required %0d", n, n_take);
    else n_pass++;
    if (n_take == N) begin
      n_checks++;
      if (rd_if.rd_valid !== 1'b0 || done !== 1'b0)
        $display("FAIL end_of_read: valid=%0b done=%0b, required 0/0", rd_if.rd_valid, done);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({armed, busy, done, rd_if.rd_valid, rd_if.rd_data} !== 6'b0)
      $display("FAIL reset_outputs: got %b, required 000000",
               {armed, busy, done, rd_if.rd_valid, rd_if.rd_data});
    else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({armed, busy, done} !== 3'b0)
      $display("FAIL idle_after_reset: got %b, required 000", {armed, busy, done});
    else n_pass++;
  endtask

  task automatic test_imm_counter();
    int  bc;
    logic any_b;
    gen = 1; man_tp = 2'b00;
    repeat (3) @(negedge clk);
    do_arm(0, 0);
    wait_done(5000, bc);
    n_checks++;
    if (bc != 1 + (N - 1)) $display("FAIL busy_cycles_p0: got %0d, required %0d", bc, N);
    else n_pass++;
    read_and_check(N, 100);
    any_b = 1'b0;
    for (int i = 0; i < N; i++) any_b |= got[i][1];
    n_checks++;
    if (any_b !== 1'b0) $display("FAIL tpb_zero: got %b, required 0", any_b);
    else n_pass++;
  endtask

  task automatic test_trig_a_rise();
    int bc, acnt;
    gen = 0; man_tp = 2'b00;
    repeat (3) @(negedge clk);
    do_arm(1, 0);
    acnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (armed) acnt++;
      @(negedge clk);
    end
    n_checks++;
    if (acnt != 50) $display("FAIL armed_wait: armed %0d cycles, required 50", acnt);
    else n_pass++;
    man_tp = 2'b01;
    repeat (3) @(negedge clk);
    gen = 3;
    wait_done(5000, bc);
    read_and_check(N, 100);
    n_checks++;
    if (got[0] !== 2'b01) $display("FAIL a_rise_sample0: got %b, required 01", got[0]);
    else n_pass++;
    // tpa already high at arm: only a fresh rising edge may trigger.
    gen = 0; man_tp = 2'b01;
    repeat (4) @(negedge clk);
    do_arm(1, 0);
    acnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (armed) acnt++;
      @(negedge clk);
    end
    n_checks++;
    if (acnt != 20) $display("FAIL a_high_no_trig: armed %0d cycles, required 20", acnt);
    else n_pass++;
    man_tp = 2'b00;
    repeat (3) @(negedge clk);
    man_tp = 2'b01;
    repeat (3) @(negedge clk);
    gen = 3;
    wait_done(5000, bc);
    read_and_check(N, 100);
    n_checks++;
    if (got[0] !== 2'b01) $display("FAIL a_rearm_sample0: got %b, required 01", got[0]);
    else n_pass++;
  endtask

  task automatic test_prescale();
    int   bc;
    logic same;
    gen = 2; man_tp = 2'b00;
    repeat (3) @(negedge clk);
    do_arm(0, 3);
    wait_done(5000, bc);
    n_checks++;
    if (bc != 1 + (N - 1) * 4) $display("FAIL busy_cycles_p3: got %0d, required %0d", bc,
                                        1 + (N - 1) * 4);
    else n_pass++;
    read_and_check(N, 100);
    same = 1'b1;
    for (int i = 1; i < N; i++) if (got[i][1] !== got[0][1]) same = 1'b0;
    n_checks++;
    if (same !== 1'b1) $display("FAIL tpb_constant: got %b, required 1", same);
    else n_pass++;
  endtask

  task automatic test_stall_readout();
    int bc;
    gen = 3;
    do_arm(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    wait_done(5000, bc);
    read_and_check(N, 30);
  endtask

  task automatic test_abort();
    int bc;
    gen = 3;
    do_arm(0, 1);
    repeat (100) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL mid_capture_busy: got %b, required 1", busy);
    else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({armed, busy, done, rd_if.rd_valid} !== 4'b0)
      $display("FAIL abort_outputs: got %b, required 0000", {armed, busy, done, rd_if.rd_valid});
    else n_pass++;
    gen = 0; man_tp = 2'b01;
    repeat (3) @(negedge clk);
    do_arm(2, 0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (armed !== 1'b1) $display("FAIL b_wait_armed: got %b, required 1", armed);
    else n_pass++;
    man_tp = 2'b11;
    repeat (3) @(negedge clk);
    gen = 3;
    wait_done(5000, bc);
    read_and_check(N, 100);
    n_checks++;
    if (got[0] !== 2'b11) $display("FAIL b_rise_sample0: got %b, required 11", got[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int bc;
    gen = 3;
    do_arm(0, 0);
    wait_done(5000, bc);
    read_and_check(17, 100);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({armed, busy, done, rd_if.rd_valid, rd_if.rd_data} !== 6'b0)
      $display("FAIL reset_in_done: got %b, required 000000",
               {armed, busy, done, rd_if.rd_valid, rd_if.rd_data});
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    do_arm(3, 1);
    wait_done(5000, bc);
    read_and_check(N, 60);
    @(negedge clk);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    n_checks++;
    if ({armed, busy} !== 2'b00) $display("FAIL arm_abort_idle: got %b, required 00", {armed, busy});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({armed, busy, done} !== 3'b000)
      $display("FAIL arm_abort_stays: got %b, required 000", {armed, busy, done});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_imm_counter();
    test_trig_a_rise();
    test_prescale();
    test_stall_readout();
    test_abort();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
